// File: rtl/accel_frame_assembler.sv
// Accelerometer frame assembler.
// Collects the six-byte burst XL, XH, YL, YH, ZL, ZH from an SPI master.
// Each axis is checked for a clean 12-bit sign extension in its high byte.
// Each good frame is presented as one signed X/Y/Z sample behind a valid/ready handshake.
// A frame that arrives while the previous sample is still unaccepted is dropped and counted.
// Malformed frames and stalled frames are discarded and counted as errors.
module accel_frame_assembler #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic signed [11:0] x_out,
    output logic signed [11:0] y_out,
    output logic signed [11:0] z_out,
    output logic [7:0]         drop_cnt,
    output logic [7:0]         err_cnt,
    output logic               busy
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    // Counter value on the cycle before the limit; the increment that would reach it fires the timeout.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_idx;
    logic [TMO_W-1:0]   r_tmo;

    // Partial frame bytes; ZH is never stored because it is evaluated as it arrives.
    logic [7:0]         r_xl;
    logic [7:0]         r_xh;
    logic [7:0]         r_yl;
    logic [7:0]         r_yh;
    logic [7:0]         r_zl;

    logic               r_valid;
    logic signed [11:0] r_x;
    logic signed [11:0] r_y;
    logic signed [11:0] r_z;
    logic [7:0]         r_drop;
    logic [7:0]         r_err;

    logic               w_collect;
    logic               w_accept;
    logic [2:0]         w_wr_idx;
    logic               w_last;
    logic               w_tmo_hit;
    logic               w_fmt_ok;
    logic               w_load;
    logic               w_drop;
    logic               w_err_inc;
    logic signed [11:0] w_x;
    logic signed [11:0] w_y;
    logic signed [11:0] w_z;

    // High byte is a legal 12-bit sign extension only if bits 7..3 all agree.
    function automatic logic fmt_ok(input logic [7:0] h);
        return (h[7:3] == 5'b00000) || (h[7:3] == 5'b11111);
    endfunction

    // Event counters stick at 255 rather than wrap.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? 8'hFF : c + 8'd1;
    endfunction

    assign w_collect = (r_state == S_COLLECT);
    // frame_start always restarts at byte 0, even with a byte on the same cycle.
    assign w_wr_idx  = frame_start ? 3'd0 : r_idx;
    assign w_accept  = byte_valid && (frame_start || w_collect);
    assign w_last    = w_collect && byte_valid && !frame_start && (r_idx == 3'd5);
    // frame_start takes priority over an expiring timeout.
    assign w_tmo_hit = w_collect && !byte_valid && !frame_start && (r_tmo == TMO_LAST);

    assign w_fmt_ok  = fmt_ok(r_xh) && fmt_ok(r_yh) && fmt_ok(byte_data);
    assign w_x       = {r_xh[3:0], r_xl};
    assign w_y       = {r_yh[3:0], r_yl};
    assign w_z       = {byte_data[3:0], r_zl};

    assign w_load    = w_last && w_fmt_ok && (!r_valid || sample_ready);
    assign w_drop    = w_last && w_fmt_ok && r_valid && !sample_ready;
    assign w_err_inc = (w_last && !w_fmt_ok) || w_tmo_hit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: frame_start always enters COLLECT; last byte or timeout returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = S_COLLECT;
        end else if (w_collect && (w_last || w_tmo_hit)) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Byte index and inter-byte timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 3'd0;
            r_tmo <= '0;
        end else if (frame_start) begin
            r_idx <= byte_valid ? 3'd1 : 3'd0;
            r_tmo <= '0;
        end else if (w_collect) begin
            if (byte_valid) begin
                r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
                r_tmo <= '0;
            end else if (w_tmo_hit) begin
                r_idx <= 3'd0;
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // Capture the first five bytes of a frame; contents only matter once a frame completes.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            case (w_wr_idx)
                3'd0:    r_xl <= byte_data;
                3'd1:    r_xh <= byte_data;
                3'd2:    r_yl <= byte_data;
                3'd3:    r_yh <= byte_data;
                3'd4:    r_zl <= byte_data;
                default: ;
            endcase
        end
    end

    // --- output stage: held sample, handshake and event counters ---
    // Holding register loads on a good frame, otherwise keeps its sample until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_x     <= w_x;
            r_y     <= w_y;
            r_z     <= w_z;
        end else if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating drop and error counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= 8'd0;
            r_err  <= 8'd0;
        end else begin
            if (w_drop) begin
                r_drop <= sat_inc(r_drop);
            end
            if (w_err_inc) begin
                r_err <= sat_inc(r_err);
            end
        end
    end

    assign sample_valid = r_valid;
    assign x_out        = r_x;
    assign y_out        = r_y;
    assign z_out        = r_z;
    assign drop_cnt     = r_drop;
    assign err_cnt      = r_err;
    assign busy         = w_collect;

endmodule
